fprint_tail_comparator: RTL and testbench

//  Consumer end of the per-task fingerprint ring buffers. For each compare job it:
//   - drives comparator_task_id and reads the tail pointers from the pointer register file;
//   - fetches one fingerprint per logical core from fingerprint RAM and compares them;
//   - reports match or mismatch;
//   - requests inc_tail_pointer, plus reset_task on the task's last fingerprint, over
//     the req/ack handshake owned by the pointer register file.

---
 rtl/fprint_comp_pkg.sv | 20 ++
 rtl/fprint_vote.sv | 39 +++
 rtl/fprint_tail_comparator.sv | 154 +++++++++++++++
 tb/tb_fprint_tail_comparator.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fprint_comp_pkg.sv
// Shared definitions for the fingerprint tail comparator: FSM states and fault-mask constants.
package fprint_comp_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_PTR,
    RD0,
    RD1,
    RD2,
    DRAIN,
    CMP,
    INC_REQ,
    RST_REQ
  } state_t;

  localparam logic [2:0] MASK_NONE = 3'b000;
  localparam logic [2:0] MASK_DMR  = 3'b011;
  localparam logic [2:0] MASK_ALL  = 3'b111;

endpackage

// File: rtl/fprint_vote.sv
// Combinational fingerprint voter: 2-way compare, or 3-way majority when FPRINT_COMP_TMR_EN is defined.
module fprint_vote
  import fprint_comp_pkg::*;
#(
  parameter int unsigned FP_WIDTH = 32
) (
  input  logic [FP_WIDTH-1:0] fp0,
  input  logic [FP_WIDTH-1:0] fp1,
`ifdef FPRINT_COMP_TMR_EN
  input  logic [FP_WIDTH-1:0] fp2,
`endif
  output logic                mismatch,
  output logic [2:0]          mask
);

`ifdef FPRINT_COMP_TMR_EN
  logic e01, e02, e12;

  always_comb begin
    e01 = (fp0 == fp1);
    e02 = (fp0 == fp2);
    e12 = (fp1 == fp2);
    mask = MASK_NONE;
    // The odd core out is the one excluded from the single agreeing pair.
    if (e01 && e02)  mask = MASK_NONE;
    else if (e01)    mask = 3'b100;
    else if (e02)    mask = 3'b010;
    else if (e12)    mask = 3'b001;
    else             mask = MASK_ALL;
    mismatch = (mask != MASK_NONE);
  end
`else
  always_comb begin
    mismatch = (fp0 != fp1);
    mask     = mismatch ? MASK_DMR : MASK_NONE;
  end
`endif

endmodule

// File: rtl/fprint_tail_comparator.sv
// Consumer end of the per-task fingerprint ring buffers: fetch, vote, then advance/reset the tail.
// Define FPRINT_COMP_TMR_EN for 3-core majority voting; default build compares cores 0 and 1 only.
module fprint_tail_comparator
  import fprint_comp_pkg::*;
#(
  parameter int unsigned KEY_WIDTH  = 4,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FP_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  job_valid,
  input  logic [KEY_WIDTH-1:0]  job_task_id,
  input  logic                  job_last,
  output logic                  job_ready,
  output logic [KEY_WIDTH-1:0]  comparator_task_id,
  input  logic [ADDR_WIDTH-1:0] comp_tail_pointer_0,
  input  logic [ADDR_WIDTH-1:0] comp_tail_pointer_1,
  input  logic [ADDR_WIDTH-1:0] comp_tail_pointer_2,
  output logic                  comparator_inc_tail_pointer,
  input  logic                  comp_inc_tail_pointer_ack,
  output logic                  comp_reset_task,
  input  logic                  comp_reset_task_ack,
  output logic                  ram_rd_en,
  output logic [1:0]            ram_rd_core,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [FP_WIDTH-1:0]   ram_rd_data,
  output logic                  result_valid,
  output logic                  result_mismatch,
  output logic [2:0]            result_fault_mask,
  output logic [KEY_WIDTH-1:0]  result_task_id
);

  state_t               state, state_next;
  logic [KEY_WIDTH-1:0] task_q;
  logic                 last_q;
  logic [FP_WIDTH-1:0]  fp0_q, fp1_q;
  logic                 vote_mismatch;
  logic [2:0]           vote_mask;

`ifdef FPRINT_COMP_TMR_EN
  logic [FP_WIDTH-1:0]  fp2_q;
`else
  logic                 unused_tail2;
  assign unused_tail2 = ^comp_tail_pointer_2;
`endif

  assign comparator_task_id = task_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      task_q <= '0;
      last_q <= 1'b0;
      fp0_q  <= '0;
      fp1_q  <= '0;
`ifdef FPRINT_COMP_TMR_EN
      fp2_q  <= '0;
`endif
    end else begin
      state <= state_next;
      if (state == IDLE && job_valid) begin
        task_q <= job_task_id;
        last_q <= job_last;
      end
      // RAM data lags the read strobe by one cycle, so each capture is one state late.
      case (state)
        RD1:   fp0_q <= ram_rd_data;
        RD2:   fp1_q <= ram_rd_data;
`ifdef FPRINT_COMP_TMR_EN
        DRAIN: fp2_q <= ram_rd_data;
`else
        DRAIN: fp1_q <= ram_rd_data;
`endif
        default: ;
      endcase
    end
  end

  fprint_vote #(
    .FP_WIDTH (FP_WIDTH)
  ) u_vote (
    .fp0      (fp0_q),
    .fp1      (fp1_q),
`ifdef FPRINT_COMP_TMR_EN
    .fp2      (fp2_q),
`endif
    .mismatch (vote_mismatch),
    .mask     (vote_mask)
  );

  always_comb begin
    state_next                  = state;
    job_ready                   = 1'b0;
    ram_rd_en                   = 1'b0;
    ram_rd_core                 = '0;
    ram_rd_addr                 = '0;
    result_valid                = 1'b0;
    result_mismatch             = 1'b0;
    result_fault_mask           = MASK_NONE;
    result_task_id              = '0;
    comparator_inc_tail_pointer = 1'b0;
    comp_reset_task             = 1'b0;
    case (state)
      IDLE: begin
        if (job_valid && !reset) begin
          job_ready  = 1'b1;
          state_next = WAIT_PTR;
        end
      end
      WAIT_PTR: state_next = RD0;
      RD0: begin
        ram_rd_en   = 1'b1;
        ram_rd_core = 2'd0;
        ram_rd_addr = comp_tail_pointer_0;
        state_next  = RD1;
      end
      RD1: begin
        ram_rd_en   = 1'b1;
        ram_rd_core = 2'd1;
        ram_rd_addr = comp_tail_pointer_1;
`ifdef FPRINT_COMP_TMR_EN
        state_next  = RD2;
`else
        state_next  = DRAIN;
`endif
      end
      RD2: begin
        ram_rd_en   = 1'b1;
        ram_rd_core = 2'd2;
        ram_rd_addr = comp_tail_pointer_2;
        state_next  = DRAIN;
      end
      DRAIN: state_next = CMP;
      CMP: begin
        result_valid      = 1'b1;
        result_mismatch   = vote_mismatch;
        result_fault_mask = vote_mask;
        result_task_id    = task_q;
        state_next        = INC_REQ;
      end
      INC_REQ: begin
        comparator_inc_tail_pointer = 1'b1;
        if (comp_inc_tail_pointer_ack) state_next = last_q ? RST_REQ : IDLE;
      end
      RST_REQ: begin
        comp_reset_task = 1'b1;
        if (comp_reset_task_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fprint_tail_comparator.sv
// Directed bench for fprint_tail_comparator with pointer-file and fingerprint-RAM models.
module tb_fprint_tail_comparator;

  logic        clk = 1'b0;
  logic        reset;
  logic        job_valid;
  logic [3:0]  job_task_id;
  logic        job_last;
  logic        job_ready;
  logic [3:0]  comparator_task_id;
  logic [9:0]  comp_tail_pointer_0, comp_tail_pointer_1, comp_tail_pointer_2;
  logic        comparator_inc_tail_pointer;
  logic        comp_inc_tail_pointer_ack;
  logic        comp_reset_task;
  logic        comp_reset_task_ack;
  logic        ram_rd_en;
  logic [1:0]  ram_rd_core;
  logic [9:0]  ram_rd_addr;
  logic [31:0] ram_rd_data;
  logic        result_valid;
  logic        result_mismatch;
  logic [2:0]  result_fault_mask;
  logic [3:0]  result_task_id;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

`ifdef FPRINT_COMP_TMR_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic [9:0]  tail0 [16];
  logic [9:0]  tail1 [16];
  logic [9:0]  tail2 [16];
  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  logic [31:0] mem2 [1024];

  always #5 clk = ~clk;

  fprint_tail_comparator #(
    .KEY_WIDTH  (4),
    .ADDR_WIDTH (10),
    .FP_WIDTH   (32)
  ) dut (
    .clk                         (clk),
    .reset                       (reset),
    .job_valid                   (job_valid),
    .job_task_id                 (job_task_id),
    .job_last                    (job_last),
    .job_ready                   (job_ready),
    .comparator_task_id          (comparator_task_id),
    .comp_tail_pointer_0         (comp_tail_pointer_0),
    .comp_tail_pointer_1         (comp_tail_pointer_1),
    .comp_tail_pointer_2         (comp_tail_pointer_2),
    .comparator_inc_tail_pointer (comparator_inc_tail_pointer),
    .comp_inc_tail_pointer_ack   (comp_inc_tail_pointer_ack),
    .comp_reset_task             (comp_reset_task),
    .comp_reset_task_ack         (comp_reset_task_ack),
    .ram_rd_en                   (ram_rd_en),
    .ram_rd_core                 (ram_rd_core),
    .ram_rd_addr                 (ram_rd_addr),
    .ram_rd_data                 (ram_rd_data),
    .result_valid                (result_valid),
    .result_mismatch             (result_mismatch),
    .result_fault_mask           (result_fault_mask),
    .result_task_id              (result_task_id)
  );

  always @(posedge clk) begin
    comp_tail_pointer_0 <= tail0[comparator_task_id];
    comp_tail_pointer_1 <= tail1[comparator_task_id];
    comp_tail_pointer_2 <= tail2[comparator_task_id];
    if (ram_rd_en) begin
      case (ram_rd_core)
        2'd0:    ram_rd_data <= mem0[ram_rd_addr];
        2'd1:    ram_rd_data <= mem1[ram_rd_addr];
        default: ram_rd_data <= mem2[ram_rd_addr];
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input string name, input logic [3:0] id, input logic last,
                         input int delay, input logic [9:0] t0, input logic [9:0] t1,
                         input logic [9:0] t2, input logic [31:0] f0, input logic [31:0] f1,
                         input logic [31:0] f2, input logic exp_mm, input logic [2:0] exp_mask,
                         input logic abort);
    int cnt;
    int held;
    int accepted;
    tail0[id] = t0; tail1[id] = t1; tail2[id] = t2;
    mem0[t0] = f0; mem1[t1] = f1; mem2[t2] = f2;
    @(negedge clk);
    job_valid = 1'b1; job_task_id = id; job_last = last;
    #1;
    check({name, "/job_ready"}, 32'(job_ready), 32'd1);
    @(negedge clk);
    job_valid = 1'b0; job_last = 1'b0;
    check({name, "/task_id"}, 32'(comparator_task_id), 32'(id));
    cnt = 1;
    while (!result_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check({name, "/latency"}, 32'(cnt), 32'(LAT));
    check({name, "/mismatch"}, 32'(result_mismatch), 32'(exp_mm));
    check({name, "/mask"}, 32'(result_fault_mask), 32'(exp_mask));
    check({name, "/res_task"}, 32'(result_task_id), 32'(id));
    @(negedge clk);
    // Offer a competing job while the increment request is pending.
    job_valid = 1'b1; job_task_id = id + 4'd1;
    #1;
    held = 0; accepted = 0;
    for (int i = 0; i < delay; i++) begin
      if (comparator_inc_tail_pointer) held++;
      if (job_ready) accepted++;
      @(negedge clk);
      #1;
    end
    check({name, "/held"}, 32'(held), 32'(delay));
    check({name, "/no_accept"}, 32'(accepted), 32'd0);
    if (abort) begin
      reset = 1'b1;
      #1;
      check({name, "/rst_inc_drop"}, 32'(comparator_inc_tail_pointer), 32'd0);
      check({name, "/rst_task_id"}, 32'(comparator_task_id), 32'd0);
      job_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      return;
    end
    check({name, "/inc_req"}, 32'(comparator_inc_tail_pointer), 32'd1);
    comp_inc_tail_pointer_ack = 1'b1;
    @(negedge clk);
    comp_inc_tail_pointer_ack = 1'b0;
    job_valid = 1'b0;
    #1;
    check({name, "/inc_drop"}, 32'(comparator_inc_tail_pointer), 32'd0);
    check({name, "/task_stable"}, 32'(comparator_task_id), 32'(id));
    check({name, "/rst_req"}, 32'(comp_reset_task), 32'(last));
    if (last) begin
      comp_reset_task_ack = 1'b1;
      @(negedge clk);
      comp_reset_task_ack = 1'b0;
      #1;
      check({name, "/rst_drop"}, 32'(comp_reset_task), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1;
    job_valid = 1'b0; job_task_id = '0; job_last = 1'b0;
    comp_inc_tail_pointer_ack = 1'b0; comp_reset_task_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("reset/task_id", 32'(comparator_task_id), 32'd0);
    check("reset/result", {26'd0, result_valid, result_mismatch, result_fault_mask, 1'b0},
          32'd0);
    check("reset/requests", {28'd0, comparator_inc_tail_pointer, comp_reset_task, ram_rd_en,
          job_ready}, 32'd0);
    reset = 1'b0;

    run_job("equal", 4'd3, 1'b0, 0, 10'h010, 10'h110, 10'h210,
            32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b000, 1'b0);
`ifdef FPRINT_COMP_TMR_EN
    run_job("diff", 4'd3, 1'b0, 0, 10'h020, 10'h120, 10'h220,
            32'h1, 32'h2, 32'h1, 1'b1, 3'b010, 1'b0);
`else
    run_job("diff", 4'd3, 1'b0, 0, 10'h020, 10'h120, 10'h220,
            32'h1, 32'h2, 32'h1, 1'b1, 3'b011, 1'b0);
`endif
    run_job("last", 4'd5, 1'b1, 2, 10'h030, 10'h130, 10'h230,
            32'h55, 32'h55, 32'h55, 1'b0, 3'b000, 1'b0);

    // Stray acks while idle must not pre-satisfy the next handshake.
    @(negedge clk);
    comp_inc_tail_pointer_ack = 1'b1; comp_reset_task_ack = 1'b1;
    @(negedge clk);
    comp_inc_tail_pointer_ack = 1'b0; comp_reset_task_ack = 1'b0;

`ifdef FPRINT_COMP_TMR_EN
    run_job("aab_slow", 4'd7, 1'b0, 10, 10'h040, 10'h140, 10'h240,
            32'hA, 32'hA, 32'hB, 1'b1, 3'b100, 1'b0);
    run_job("abc_abort", 4'd9, 1'b0, 3, 10'h050, 10'h150, 10'h250,
            32'hA, 32'hB, 32'hC, 1'b1, 3'b111, 1'b1);
    run_job("baa_post", 4'd2, 1'b1, 1, 10'h060, 10'h160, 10'h260,
            32'hB, 32'hA, 32'hA, 1'b1, 3'b001, 1'b0);
`else
    run_job("aab_slow", 4'd7, 1'b0, 10, 10'h040, 10'h140, 10'h240,
            32'hA, 32'hA, 32'hB, 1'b0, 3'b000, 1'b0);
    run_job("abc_abort", 4'd9, 1'b0, 3, 10'h050, 10'h150, 10'h250,
            32'hA, 32'hB, 32'hC, 1'b1, 3'b011, 1'b1);
    run_job("baa_post", 4'd2, 1'b1, 1, 10'h060, 10'h160, 10'h260,
            32'hB, 32'hA, 32'hA, 1'b1, 3'b011, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
